// File: rtl/seg_scan_controller.sv
// Multiplexed 7-seg scanner: frame-synchronous display copy, blanking gap per digit, optional leading-zero blanking.
// Outputs registered (reflect state of the current cycle); load is always accepted, last load in a frame wins.
module seg_scan_controller #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            digit_num,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_tick
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0][3:0]   disp_q, disp_d;
    logic [DIGITS-1:0]        dpr_q, dpr_d;
    logic [DIGITS-1:0][3:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]        pend_dp_q, pend_dp_d;
    logic                     pend_vld_q, pend_vld_d;

    logic [3:0]               digit_num_q, digit_num_d;
    logic [DIGITS-1:0]        an_q, an_d;
    logic                     dp_q, dp_d;
    logic                     frame_tick_q, frame_tick_d;

    logic                     slot_end;
    logic                     boundary;
    logic [DIGITS-1:0]        upper_zero;
    logic                     zero_acc;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        slot_end = (state_q == ST_SHOW) && (cnt_q == CNT_W'(REFRESH_DIV - 1));
        boundary = slot_end && (idx_q == IDX_W'(DIGITS - 1));

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (slot_end) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // A load on the boundary cycle itself bypasses the pending stage.
    always_comb begin
        disp_d     = disp_q;
        dpr_d      = dpr_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_vld_d = pend_vld_q;

        if (load) begin
            pend_val_d = value_in;
            pend_dp_d  = dp_in;
            pend_vld_d = 1'b1;
        end

        if (boundary) begin
            if (load) begin
                disp_d = value_in;
                dpr_d  = dp_in;
            end else if (pend_vld_q) begin
                disp_d = pend_val_q;
                dpr_d  = pend_dp_q;
            end
            pend_vld_d = 1'b0;
        end
    end

    // upper_zero[i]: display digits i..DIGITS-1 are all zero.
    always_comb begin
        upper_zero = '0;
        zero_acc   = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_acc      = zero_acc & (disp_d[i] == 4'h0);
            upper_zero[i] = zero_acc;
        end
    end

    always_comb begin
        an_d         = '1;
        dp_d         = 1'b1;
        frame_tick_d = boundary;
        if (lz_en && (idx_d != '0) && upper_zero[idx_d]) begin
            digit_num_d = 4'hF;
        end else begin
            digit_num_d = disp_d[idx_d];
        end
        if (state_d == ST_SHOW) begin
            an_d[idx_d] = 1'b0;
            dp_d        = ~dpr_d[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            dpr_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            digit_num_q  <= 4'hF;
            an_q         <= '1;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            dpr_q        <= dpr_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            digit_num_q  <= digit_num_d;
            an_q         <= an_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign digit_num  = digit_num_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
